// File: rtl/cpu_pkg.sv
// Shared CPU-wide register file types and default sizes.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: zero-register forcing, write bypass and busy qualification.
module regfile_sb_rdport
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] rdAddr_i,
    input  logic [DATA_W-1:0] storedData_i,
    input  logic              storedBusy_i,
    input  logic              waEn_i,
    input  logic [ADDR_W-1:0] waAddr_i,
    input  logic [DATA_W-1:0] waData_i,
    input  logic              wbEn_i,
    input  logic [ADDR_W-1:0] wbAddr_i,
    input  logic [DATA_W-1:0] wbData_i,
    output logic [DATA_W-1:0] rdData_o,
    output logic              rdBusy_o
);

    logic isZero;
    logic waHit;
    logic wbHit;

    assign isZero = (ZERO_REG != 0) && (rdAddr_i == ADDR_W'(REG_ZERO));
    assign waHit  = (BYPASS != 0) && waEn_i && (waAddr_i == rdAddr_i);
    assign wbHit  = (BYPASS != 0) && wbEn_i && (wbAddr_i == rdAddr_i);

    // Port B carries the younger result, so it takes precedence over port A.
    always_comb begin
        rdData_o = storedData_i;
        if (isZero) begin
            rdData_o = '0;
        end else if (wbHit) begin
            rdData_o = wbData_i;
        end else if (waHit) begin
            rdData_o = waData_i;
        end
    end

    assign rdBusy_o = storedBusy_i && !isZero && !(waHit || wbHit);

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with two write ports, bypass and a pending-write scoreboard.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
    output logic [NUM_RD*DATA_W-1:0] RD_DATA,
    output logic [NUM_RD-1:0]        RD_BUSY,
    input  logic                     WA_EN,
    input  logic [ADDR_W-1:0]        WA_ADDR,
    input  logic [DATA_W-1:0]        WA_DATA,
    input  logic                     WB_EN,
    input  logic [ADDR_W-1:0]        WB_ADDR,
    input  logic [DATA_W-1:0]        WB_DATA,
    input  logic                     ISS_EN,
    input  logic [ADDR_W-1:0]        ISS_ADDR,
    output logic [ADDR_W:0]          PEND_CNT,
    output logic                     IDLE
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regQ [DEPTH];
    logic [DEPTH-1:0]  busyQ;
    logic [DEPTH-1:0]  busyD;
    logic [ADDR_W:0]   pendCntQ;
    logic [ADDR_W:0]   pendCntD;
    logic [ADDR_W:0]   setCnt;
    logic [ADDR_W:0]   clrCnt;
    logic              waOk;
    logic              wbOk;
    logic              issOk;

    assign waOk  = WA_EN  && !((ZERO_REG != 0) && (WA_ADDR  == ADDR_W'(REG_ZERO)));
    assign wbOk  = WB_EN  && !((ZERO_REG != 0) && (WB_ADDR  == ADDR_W'(REG_ZERO)));
    assign issOk = ISS_EN && !((ZERO_REG != 0) && (ISS_ADDR == ADDR_W'(REG_ZERO)));

    // Writes retire producers; an issue in the same cycle re-arms the bit afterwards.
    always_comb begin
        busyD = busyQ;
        if (waOk) begin
            busyD[WA_ADDR] = 1'b0;
        end
        if (wbOk) begin
            busyD[WB_ADDR] = 1'b0;
        end
        if (issOk) begin
            busyD[ISS_ADDR] = 1'b1;
        end
    end

    always_comb begin
        setCnt = '0;
        clrCnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            setCnt = setCnt + {{ADDR_W{1'b0}}, busyD[i] & ~busyQ[i]};
            clrCnt = clrCnt + {{ADDR_W{1'b0}}, busyQ[i] & ~busyD[i]};
        end
        pendCntD = pendCntQ + setCnt - clrCnt;
    end

    // Port B is assigned last so it wins a same-address collision with port A.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regQ[i] <= '0;
            end
            busyQ    <= '0;
            pendCntQ <= '0;
        end else begin
            if (waOk) begin
                regQ[WA_ADDR] <= WA_DATA;
            end
            if (wbOk) begin
                regQ[WB_ADDR] <= WB_DATA;
            end
            busyQ    <= busyD;
            pendCntQ <= pendCntD;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : gRdPort
        logic [ADDR_W-1:0] portAddr;
        assign portAddr = RD_ADDR[g*ADDR_W +: ADDR_W];

        regfile_sb_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) uRdPort (
            .rdAddr_i     (portAddr),
            .storedData_i (regQ[portAddr]),
            .storedBusy_i (busyQ[portAddr]),
            .waEn_i       (WA_EN),
            .waAddr_i     (WA_ADDR),
            .waData_i     (WA_DATA),
            .wbEn_i       (WB_EN),
            .wbAddr_i     (WB_ADDR),
            .wbData_i     (WB_DATA),
            .rdData_o     (RD_DATA[g*DATA_W +: DATA_W]),
            .rdBusy_o     (RD_BUSY[g])
        );
    end

    assign PEND_CNT = pendCntQ;
    assign IDLE     = (pendCntQ == '0);

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Configurable data width, depth and read-port count.
- Two write ports: port A is the ALU/early writeback, port B is the load/late writeback.
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard, so the pipelined CPU can detect RAW hazards and stall issue.
- Sits between decode (read and issue side) and writeback.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never marked busy
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value only

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- RD_ADDR  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- RD_DATA  out  NUM_RD*DATA_W  read data per port, combinational
- RD_BUSY  out  NUM_RD  per read port: addressed register has a pending write not satisfied this cycle
- WA_EN  in  1  write port A enable
- WA_ADDR  in  ADDR_W  write port A address
- WA_DATA  in  DATA_W  write port A data
- WB_EN  in  1  write port B enable
- WB_ADDR  in  ADDR_W  write port B address
- WB_DATA  in  DATA_W  write port B data
- ISS_EN  in  1  issue: mark destination register pending
- ISS_ADDR  in  ADDR_W  destination of issued instruction
- PEND_CNT  out  ADDR_W+1  number of registers currently marked busy (registered)
- IDLE  out  1  high when PEND_CNT == 0

Behaviour:
Clock and reset:
- Single clock domain; all storage updates on posedge CLK.
- RST high at an edge: all registers <= 0, all busy bits <= 0, PEND_CNT <= 0.
- Reset overrides any write or issue in the same cycle. Mid-operation reset discards all pending state.
- After reset: RD_DATA = 0 (unless bypassing a write), RD_BUSY = 0, IDLE = 1.

Writes:
- Enabled write to address a: reg[a] <= data at the edge.
- ZERO_REG=1 and a == 0: write ignored, reg[0] stays 0.
- WA_EN and WB_EN to the same address in the same cycle: port B wins (it is the younger result).
- Different addresses: both writes commit.

Reads (combinational, zero latency):
- BYPASS=1, priority order: (1) ZERO_REG and addr == 0 -> 0; (2) WB_EN and WB_ADDR == addr -> WB_DATA; (3) WA_EN and WA_ADDR == addr -> WA_DATA; (4) stored value.
- BYPASS=0: rule 1 then the stored value only.
- Read ports are independent; any ports may share an address.

Scoreboard:
- One busy bit per register.
- Clear: an enabled write on either port clears busy[a].
- Set: ISS_EN sets busy[ISS_ADDR]. It is ignored when ZERO_REG=1 and ISS_ADDR == 0.
- Issue and write to the same register in the same cycle: set wins, so busy stays 1 (a new producer is outstanding).
- Issue to an already-busy register with no write: busy stays 1 and PEND_CNT is unchanged. There is no nesting; one outstanding producer is tracked per register.
- RD_BUSY[i] = busy[addr_i] and not (BYPASS and an enabled write to addr_i this cycle). Forwarded data counts as satisfied.
- RD_BUSY[i] is always 0 for address 0 when ZERO_REG=1.
- RD_BUSY does not include an issue in the same cycle; the decoder handles that itself.

Pending counter:
- PEND_CNT next = current + (busy bits newly set) − (busy bits newly cleared).
- Net change per cycle is in −2..+1.
- Never wraps: at most 2**ADDR_W bits can be set, and the width is ADDR_W+1.
- IDLE is decoded from registered PEND_CNT.

Decomposition:
- Shared package cpu_pkg: DATA_W/ADDR_W defaults, REG_ZERO address constant, reg_addr_t and word_t typedefs.
- One sub-module, regfile_sb_rdport: per-port bypass mux plus busy qualification, instantiated NUM_RD times via generate.
- Storage, write arbitration, scoreboard and counter stay in the top level.

Test Plan:
- Reset: RST=1 for 1 cycle after random writes -> all RD_DATA=0, RD_BUSY=0, PEND_CNT=0, IDLE=1.
- Write port A reg 5 = 0x12345678, read reg 5 on port 0 in the same cycle -> bypassed 0x12345678. Next cycle with WA_EN=0 -> stored 0x12345678.
- WA and WB both write reg 9 (0xAAAA0000, 0x0000BBBB) -> same-cycle read and later read both return 0x0000BBBB.
- Write 0xFFFFFFFF to reg 0 and issue to reg 0 -> RD_DATA=0, RD_BUSY=0, PEND_CNT unchanged.
- Issue reg 3, then reg 7 -> PEND_CNT=2, RD_BUSY high for reg 3. Then WA writes reg 3 while ISS reg 3 -> busy[3] stays 1, PEND_CNT=2. Then WA writes reg 3 and WB writes reg 7 -> PEND_CNT=0, IDLE=1.
- BYPASS=0 build: write reg 4 = 0x55 while reading reg 4 -> old value 0 and RD_BUSY=1 if reg 4 was issued. Next cycle -> 0x55 and RD_BUSY=0.
